// File: rtl/pkt_to_wr_burst.sv
// Packet stream to write-burst adapter: buffers one framed packet, then replays
// it as a contiguous wren_o burst with the packet length held on cntr_o.
module pkt_to_wr_burst #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic              ready_o,
    output logic              wren_o,
    output logic [AWIDTH-1:0] cntr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              last_o,
    output logic              err_o,
    output logic              drop_o,
    output logic [1:0]        state_o
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] MAX_CNT = {AWIDTH{1'b1}};
    localparam logic [AWIDTH-1:0] ONE     = AWIDTH'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, REPLAY = 2'd2} state_t;

    state_t            state, state_nx;
    logic [AWIDTH-1:0] wcnt, wcnt_nx, len, len_nx, rdptr, rdptr_nx, cntr_nx;
    logic [DWIDTH-1:0] data_nx;
    logic              wren_nx, last_nx, err_nx, drop_nx;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem [DEPTH];

    // Handshake: a word is taken on any edge with val_i=1; there is no per-word
    // backpressure. ready_o only advertises whether a new sop would be kept
    // (low while replaying); a sop seen while ready_o=0 is dropped.
    assign ready_o = (state != REPLAY);
    assign state_o = state;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        len_nx   = len;
        rdptr_nx = rdptr;
        cntr_nx  = cntr_o;
        data_nx  = '0;
        wren_nx  = 1'b0;
        last_nx  = 1'b0;
        err_nx   = 1'b0;
        drop_nx  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = wcnt;
        case (state)
            IDLE: begin
                rdptr_nx = '0;
                if (val_i && sop_i) begin
                    mem_we   = 1'b1;
                    mem_addr = '0;
                    wcnt_nx  = ONE;
                    len_nx   = ONE;
                    state_nx = eop_i ? REPLAY : RECV;
                end
            end
            RECV: begin
                rdptr_nx = '0;
                if (val_i) begin
                    if (sop_i) begin
                        // restart: the old packet is abandoned, this word opens a new one
                        err_nx   = 1'b1;
                        mem_we   = 1'b1;
                        mem_addr = '0;
                        wcnt_nx  = ONE;
                        len_nx   = ONE;
                        state_nx = eop_i ? REPLAY : RECV;
                    end else if (wcnt == MAX_CNT) begin
                        err_nx   = 1'b1;
                        wcnt_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        mem_we  = 1'b1;
                        wcnt_nx = wcnt + ONE;
                        if (eop_i) begin
                            len_nx   = wcnt + ONE;
                            state_nx = REPLAY;
                        end
                    end
                end
            end
            REPLAY: begin
                drop_nx = val_i && sop_i;
                cntr_nx = len;
                if (rdptr == len) begin
                    wcnt_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    wren_nx  = 1'b1;
                    data_nx  = mem[rdptr];
                    last_nx  = (rdptr == len - ONE);
                    rdptr_nx = rdptr + ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            wcnt   <= '0;
            len    <= '0;
            rdptr  <= '0;
            cntr_o <= '0;
            data_o <= '0;
            wren_o <= 1'b0;
            last_o <= 1'b0;
            err_o  <= 1'b0;
            drop_o <= 1'b0;
        end else begin
            state  <= state_nx;
            wcnt   <= wcnt_nx;
            len    <= len_nx;
            rdptr  <= rdptr_nx;
            cntr_o <= cntr_nx;
            data_o <= data_nx;
            wren_o <= wren_nx;
            last_o <= last_nx;
            err_o  <= err_nx;
            drop_o <= drop_nx;
        end
    end

    // packet buffer is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_addr] <= data_i;
    end

endmodule

// File: tb/tb_pkt_to_wr_burst.sv
// Bench for pkt_to_wr_burst: directed scenarios plus random packet traffic,
// checked cycle by cycle against a packet-level reference model.
module tb_pkt_to_wr_burst;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MAX_LEN = (1 << AW) - 1;

    logic          clk, rst_n;
    logic [DW-1:0] data_i;
    logic          sop_i, eop_i, val_i;
    logic          ready_o, wren_o, last_o, err_o, drop_o;
    logic [AW-1:0] cntr_o;
    logic [DW-1:0] data_o;
    logic [1:0]    state_o;

    pkt_to_wr_burst #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .sop_i(sop_i),
        .eop_i(eop_i), .val_i(val_i), .ready_o(ready_o), .wren_o(wren_o),
        .cntr_o(cntr_o), .data_o(data_o), .last_o(last_o), .err_o(err_o),
        .drop_o(drop_o), .state_o(state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    typedef struct {
        int          edge_no;
        logic [DW-1:0] data;
        logic        last;
        logic [AW-1:0] len;
    } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] pkt[$];
    logic [DW-1:0] tx_q[$];
    bit            in_pkt;
    int            busy_until;
    bit            exp_err, exp_drop;
    int            edge_cnt;
    int            n_checks, n_fail;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endfunction

    // reference model: packet accepted at edge e replays on edges e+1..e+len,
    // and no new packet is taken until edge e+len+1 has passed
    task automatic launch(input int e);
        int n;
        n = pkt.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back('{e + 1 + i, pkt[i], (i == n - 1), AW'(n)});
        busy_until = e + n + 1;
        in_pkt = 0;
        pkt.delete();
    endtask

    task automatic model_edge(input bit v, input bit s, input bit eo,
                              input logic [DW-1:0] d, input int e);
        exp_err  = 0;
        exp_drop = 0;
        if (v) begin
            if (e <= busy_until) begin
                if (s) exp_drop = 1;
            end else if (s) begin
                if (in_pkt) exp_err = 1;
                pkt.delete();
                pkt.push_back(d);
                in_pkt = 1;
                if (eo) launch(e);
            end else if (in_pkt) begin
                if (pkt.size() == MAX_LEN) begin
                    exp_err = 1;
                    in_pkt  = 0;
                    pkt.delete();
                end else begin
                    pkt.push_back(d);
                    if (eo) launch(e);
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_w;
        exp_w = (exp_q.size() != 0) && (exp_q[0].edge_no == edge_cnt);
        chk("ready", 32'(ready_o), 32'(edge_cnt >= busy_until));
        chk("wren", 32'(wren_o), 32'(exp_w));
        if (exp_w) begin
            chk("data", 32'(data_o), 32'(exp_q[0].data));
            chk("last", 32'(last_o), 32'(exp_q[0].last));
            chk("cntr", 32'(cntr_o), 32'(exp_q[0].len));
            void'(exp_q.pop_front());
        end else begin
            chk("last_idle", 32'(last_o), 32'd0);
        end
        chk("err", 32'(err_o), 32'(exp_err));
        chk("drop", 32'(drop_o), 32'(exp_drop));
    endtask

    // driver tasks
    task automatic cycle(input bit v, input bit s, input bit eo, input logic [DW-1:0] d);
        val_i  = v;
        sop_i  = s;
        eop_i  = eo;
        data_i = d;
        @(posedge clk);
        edge_cnt++;
        model_edge(v, s, eo, d, edge_cnt);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, DW'($urandom));
    endtask

    task automatic send_q(input int gap_pct, input int abort_pos);
        int n;
        n = tx_q.size();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) cycle(1'b0, 1'b0, 1'b0, DW'($urandom));
            cycle(1'b1, (i == 0) || (i == abort_pos), (i == n - 1), tx_q[i]);
        end
        tx_q.delete();
    endtask

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(DW'($urandom));
    endtask

    task automatic check_reset_values();
        chk("rst_wren", 32'(wren_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_cntr", 32'(cntr_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
    endtask

    task automatic apply_reset();
        val_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        pkt.delete();
        in_pkt     = 0;
        busy_until = 0;
        exp_err    = 0;
        exp_drop   = 0;
        repeat (2) begin
            @(posedge clk);
            edge_cnt++;
        end
        #3 rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        edge_cnt   = 0;
        busy_until = 0;
        in_pkt     = 0;
        data_i     = '0;
        rst_n      = 1'b1;
        #2;
        apply_reset();
        idle(2);

        // 4-word packet, no gaps
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_q(0, -1);
        idle(6);
        // single-word packet
        tx_q = '{8'hA5};
        send_q(0, -1);
        idle(4);
        // stray words without sop in idle are ignored
        cycle(1'b1, 1'b0, 1'b0, 8'h5A);
        cycle(1'b1, 1'b0, 1'b1, 8'h5B);
        idle(2);
        // longest legal packet with gaps, then one word too many
        fill_random(MAX_LEN);
        send_q(40, -1);
        idle(MAX_LEN + 3);
        fill_random(MAX_LEN + 1);
        send_q(20, -1);
        idle(4);
        // restart: sop on third word of A, B is 3 words
        tx_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2};
        send_q(0, 2);
        idle(6);
        // sop during a burst is dropped, burst continues
        tx_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_q(0, -1);
        tx_q = '{8'hD0, 8'hD1, 8'hD2};
        send_q(0, -1);
        idle(8);
        // reset in the middle of a burst
        fill_random(8);
        send_q(0, -1);
        idle(3);
        apply_reset();
        tx_q = '{8'h71, 8'h72, 8'h73};
        send_q(0, -1);
        idle(6);

        // random traffic, including overflows, restarts and drops
        for (int p = 0; p < 60; p++) begin
            int n, ab;
            n  = $urandom_range(1, MAX_LEN + 2);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, n) : -1;
            fill_random(n);
            send_q($urandom_range(0, 30), ab);
            for (int g = $urandom_range(0, 20); g > 0; g--)
                cycle($urandom_range(0, 4) == 0, 1'b0, $urandom_range(0, 1) == 1, DW'($urandom));
        end
        idle(MAX_LEN + 4);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
